bicubic_upsample_sched: RTL and testbench

//  Time-multiplexes one 8-bit, 16-in/16-out combinational bicubic upsample core across the colour channels of a 4x4 RGB window.

---
 rtl/bicubic_upsample_sched_pkg.sv | 37 +++
 rtl/bicubic_upsample_sched_ch_slice.sv | 31 +++
 rtl/bicubic_upsample_sched.sv | 134 +++++++++++++
 tb/tb_bicubic_upsample_sched.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bicubic_upsample_sched_pkg.sv
// Shared definitions for the bicubic upsample scheduler: channel geometry,
// one-hot FSM encoding and FSM helper functions.
// Optional feature macro: BCCI_PERF_CNT_EN (adds busy/stall perf counters).
package bicubic_upsample_sched_pkg;

  localparam int CHANNEL_WIDTH = 8;
  localparam int CHANNEL_NUM   = 3;
  localparam int PERF_CNT_W    = 32;
  localparam int WIN_PIX       = 16;
  localparam int PIX_W         = CHANNEL_NUM * CHANNEL_WIDTH;
  localparam int WIN_W         = WIN_PIX * PIX_W;
  localparam int CORE_W        = WIN_PIX * CHANNEL_WIDTH;

  // One-hot encoding; bits [3:1] double as the channel select vector.
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_CH0  = 5'b00010,
    ST_CH1  = 5'b00100,
    ST_CH2  = 5'b01000,
    ST_OUT  = 5'b10000
  } state_e;

  function automatic logic [CHANNEL_NUM-1:0] state_ch_sel(input state_e s);
    logic [4:0] v;
    v = s;
    return v[3:1];
  endfunction

  function automatic state_e ch_next(input state_e s);
    case (s)
      ST_CH0:  return ST_CH1;
      ST_CH1:  return ST_CH2;
      default: return ST_OUT;
    endcase
  endfunction

endpackage

// File: rtl/bicubic_upsample_sched_ch_slice.sv
// Combinational gather/scatter between the packed RGB window and the
// single-channel core: picks channel c of all 16 pixels for the core and
// builds the write mask/data that drop the 16 core results into channel c.
module bicubic_upsample_sched_ch_slice
  import bicubic_upsample_sched_pkg::*;
(
  input  logic [CHANNEL_NUM-1:0] ch_sel,
  input  logic [WIN_W-1:0]       win,
  input  logic [CORE_W-1:0]      rsp,
  output logic [CORE_W-1:0]      core_p,
  output logic [WIN_W-1:0]       wr_mask,
  output logic [WIN_W-1:0]       wr_data
);

  // Gather the selected channel and spread core results to every channel lane
  always_comb begin
    core_p  = '0;
    wr_mask = '0;
    wr_data = '0;
    for (int k = 0; k < WIN_PIX; k++) begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        core_p[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
          core_p[k*CHANNEL_WIDTH +: CHANNEL_WIDTH] |
          ({CHANNEL_WIDTH{ch_sel[c]}} & win[k*PIX_W + c*CHANNEL_WIDTH +: CHANNEL_WIDTH]);
        wr_mask[k*PIX_W + c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = {CHANNEL_WIDTH{ch_sel[c]}};
        wr_data[k*PIX_W + c*CHANNEL_WIDTH +: CHANNEL_WIDTH] = rsp[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
      end
    end
  end

endmodule

// File: rtl/bicubic_upsample_sched.sv
// Bicubic upsample scheduler: accepts a 4x4 RGB window, runs each colour
// channel through a shared single-channel combinational core on successive
// cycles and presents the gathered 16-pixel RGB result downstream.
// Optional feature macro: BCCI_PERF_CNT_EN adds perf_busy_cnt/perf_stall_cnt.
module bicubic_upsample_sched
  import bicubic_upsample_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bf_req_valid,
  output logic              bcci_req_ready,
  input  logic [WIN_W-1:0]  bf_req_data,
  output logic              core_req_valid,
  output logic [CORE_W-1:0] core_p,
  output logic              core_rsp_ready,
  input  logic              core_rsp_valid,
  input  logic [CORE_W-1:0] core_rsp_data,
  output logic              bcci_rsp_valid,
  output logic [WIN_W-1:0]  bcci_rsp_data,
  input  logic              bf_rsp_ready
`ifdef BCCI_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_busy_cnt,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt
`endif
);

  state_e            state_q, state_d;
  logic              init_q, init_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [WIN_W-1:0]  out_q, out_d;
  logic [WIN_W-1:0]  wr_mask;
  logic [WIN_W-1:0]  wr_data;

  bicubic_upsample_sched_ch_slice u_slice (
    .ch_sel  (state_ch_sel(state_q)),
    .win     (win_q),
    .rsp     (core_rsp_data),
    .core_p  (core_p),
    .wr_mask (wr_mask),
    .wr_data (wr_data)
  );

  assign bcci_rsp_data = out_q;

  // Next-state, register loads and handshake outputs
  always_comb begin
    state_d        = state_q;
    init_d         = 1'b1;
    win_d          = win_q;
    out_d          = out_q;
    bcci_req_ready = 1'b0;
    core_req_valid = 1'b0;
    core_rsp_ready = 1'b0;
    bcci_rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // init_q keeps ready low until the first clock after reset release
        bcci_req_ready = init_q;
        if (bf_req_valid && init_q) begin
          win_d   = bf_req_data;
          state_d = ST_CH0;
        end
      end
      ST_CH0, ST_CH1, ST_CH2: begin
        core_req_valid = 1'b1;
        core_rsp_ready = 1'b1;
        if (core_rsp_valid) begin
          out_d   = (out_q & ~wr_mask) | (wr_data & wr_mask);
          state_d = ch_next(state_q);
        end
      end
      ST_OUT: begin
        bcci_rsp_valid = 1'b1;
        // A new window can only enter as the current result leaves
        bcci_req_ready = bf_rsp_ready;
        if (bf_rsp_ready) begin
          if (bf_req_valid) begin
            win_d   = bf_req_data;
            state_d = ST_CH0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state plus input/output window registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
      win_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      win_q   <= win_d;
      out_q   <= out_d;
    end
  end

`ifdef BCCI_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] busy_q, busy_d;
  logic [PERF_CNT_W-1:0] stall_q, stall_d;

  // Saturating increments for busy and downstream-stall cycles
  always_comb begin
    busy_d  = busy_q;
    stall_d = stall_q;
    if ((state_q != ST_IDLE) && (busy_q != '1))
      busy_d = busy_q + PERF_CNT_W'(1);
    if (bcci_rsp_valid && !bf_rsp_ready && (stall_q != '1))
      stall_d = stall_q + PERF_CNT_W'(1);
  end

  // Perf counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      stall_q <= '0;
    end else begin
      busy_q  <= busy_d;
      stall_q <= stall_d;
    end
  end

  assign perf_busy_cnt  = busy_q;
  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_bicubic_upsample_sched.sv
// Directed bench for bicubic_upsample_sched with a behavioural bicubic core.
module tb_bicubic_upsample_sched;

  localparam int W  = 384;
  localparam int CW = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bf_req_valid;
  logic          bcci_req_ready;
  logic [W-1:0]  bf_req_data;
  logic          core_req_valid;
  logic [CW-1:0] core_p;
  logic          core_rsp_ready;
  logic          core_rsp_valid;
  logic [CW-1:0] core_rsp_data;
  logic          bcci_rsp_valid;
  logic [W-1:0]  bcci_rsp_data;
  logic          bf_rsp_ready;
`ifdef BCCI_PERF_CNT_EN
  logic [31:0]   perf_busy_cnt;
  logic [31:0]   perf_stall_cnt;
`endif

  logic core_stall;
  int   errors = 0;
  int   checks = 0;
  int   creq_cnt = 0;
  int   vld_cnt = 0;
  int   hs_cnt = 0;

  always #5 clk = ~clk;

  bicubic_upsample_sched dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bf_req_valid   (bf_req_valid),
    .bcci_req_ready (bcci_req_ready),
    .bf_req_data    (bf_req_data),
    .core_req_valid (core_req_valid),
    .core_p         (core_p),
    .core_rsp_ready (core_rsp_ready),
    .core_rsp_valid (core_rsp_valid),
    .core_rsp_data  (core_rsp_data),
    .bcci_rsp_valid (bcci_rsp_valid),
    .bcci_rsp_data  (bcci_rsp_data),
    .bf_rsp_ready   (bf_rsp_ready)
`ifdef BCCI_PERF_CNT_EN
    ,
    .perf_busy_cnt  (perf_busy_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Reference bicubic core: outputs at positions {1, 1.5, 2, 2.5} per axis,
  // Catmull-Rom half-pel taps, edge-clamped, rounded, clamped to 0..255.
  function automatic logic [CW-1:0] core_model(input logic [CW-1:0] p);
    int w [4][4];
    int acc;
    int v;
    logic [CW-1:0] r;
    w = '{'{0, 16, 0, 0}, '{-1, 9, 9, -1}, '{0, 0, 16, 0}, '{0, -1, 9, 8}};
    r = '0;
    for (int ro = 0; ro < 4; ro++) begin
      for (int co = 0; co < 4; co++) begin
        acc = 0;
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            acc += w[ro][i] * w[co][j] * int'({24'd0, p[(i*4+j)*8 +: 8]});
        v = (acc + 128) >>> 8;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        r[(ro*4+co)*8 +: 8] = v[7:0];
      end
    end
    return r;
  endfunction

  always_comb begin
    core_rsp_valid = core_req_valid & ~core_stall;
    core_rsp_data  = core_stall ? {16{8'hE7}} : core_model(core_p);
  end

  always @(negedge clk) begin
    if (core_req_valid) creq_cnt <= creq_cnt + 1;
    if (bcci_rsp_valid) vld_cnt <= vld_cnt + 1;
    if (bcci_rsp_valid && bf_rsp_ready) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_flat(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    logic [W-1:0] w;
    for (int k = 0; k < 16; k++) w[k*24 +: 24] = {b, g, r};
    return w;
  endfunction

  function automatic logic [W-1:0] mk_win(input logic [CW-1:0] r, input logic [CW-1:0] g, input logic [CW-1:0] b);
    logic [W-1:0] w;
    for (int k = 0; k < 16; k++) w[k*24 +: 24] = {b[k*8 +: 8], g[k*8 +: 8], r[k*8 +: 8]};
    return w;
  endfunction

  function automatic logic [CW-1:0] plane(input logic [W-1:0] w, input int c);
    logic [CW-1:0] p;
    for (int k = 0; k < 16; k++) p[k*8 +: 8] = w[k*24 + c*8 +: 8];
    return p;
  endfunction

  // Offer one window, wait for its result; optionally stall the core in one channel
  task automatic send(input logic [W-1:0] win, input int stall_ch, input int stall_n,
                      output logic [W-1:0] got, output int lat);
    int n;
    n = 0;
    bf_req_data  = win;
    bf_req_valid = 1'b1;
    while (!bcci_req_ready && n < 40) begin
      tick();
      n++;
    end
    chk_i("accept_ready", int'(bcci_req_ready), 1);
    tick();
    bf_req_valid = 1'b0;
    bf_req_data  = {12{32'hDEADBEEF}};
    lat = 1;
    while (lat < 40) begin
      core_stall = (stall_n > 0) && (lat >= stall_ch + 1) && (lat < stall_ch + 1 + stall_n);
      if (core_stall) begin
        chk("stall_core_p", W'(core_p), W'(plane(win, stall_ch)));
      end
      if (bcci_rsp_valid) break;
      tick();
      lat++;
    end
    core_stall = 1'b0;
    got = bcci_rsp_data;
  endtask

  typedef struct {
    logic [7:0] r, g, b;
    logic [7:0] er, eg, eb;
  } vec_t;

  initial begin
    vec_t         tbl [5];
    logic [W-1:0] got;
    logic [W-1:0] bb [3];
    logic [W-1:0] bgot [3];
    logic [W-1:0] exp_w;
    logic [CW-1:0] ramp;
    int lat, c0, v0, h0, nout, nacc, widx, bad;
    int tout [3];
    int tacc [2];
    logic rv, acc;
`ifdef BCCI_PERF_CNT_EN
    int s0;
`endif

    tbl[0] = '{8'h40, 8'h80, 8'hC0, 8'h40, 8'h80, 8'hC0};
    tbl[1] = '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00};
    tbl[2] = '{8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF};
    tbl[3] = '{8'h12, 8'h34, 8'h56, 8'h12, 8'h34, 8'h56};
    tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    rst_n        = 1'b0;
    bf_req_valid = 1'b0;
    bf_req_data  = '0;
    bf_rsp_ready = 1'b1;
    core_stall   = 1'b0;
    repeat (3) tick();

    chk_i("rst_req_ready", int'(bcci_req_ready), 0);
    chk_i("rst_rsp_valid", int'(bcci_rsp_valid), 0);
    chk_i("rst_core_req_valid", int'(core_req_valid), 0);
    chk_i("rst_core_rsp_ready", int'(core_rsp_ready), 0);
    chk("rst_rsp_data", bcci_rsp_data, '0);
    rst_n = 1'b1;
    tick();
    chk_i("idle_req_ready", int'(bcci_req_ready), 1);

    // Flat windows: every output pixel equals the input colour
    for (int i = 0; i < 5; i++) begin
      c0 = creq_cnt;
      v0 = vld_cnt;
      send(mk_flat(tbl[i].r, tbl[i].g, tbl[i].b), 0, 0, got, lat);
      chk_i($sformatf("flat%0d_latency", i), lat, 4);
      chk($sformatf("flat%0d_data", i), got, mk_flat(tbl[i].er, tbl[i].eg, tbl[i].eb));
      tick();
      chk_i($sformatf("flat%0d_core_req_cycles", i), creq_cnt - c0, 3);
      chk_i($sformatf("flat%0d_valid_cycles", i), vld_cnt - v0, 1);
    end

    // Back-to-back windows with bf_req_valid held high
    bb[0] = mk_flat(8'h01, 8'h02, 8'h03);
    bb[1] = mk_flat(8'hA0, 8'hB0, 8'hC0);
    bb[2] = mk_flat(8'hFE, 8'h7F, 8'h01);
    tout = '{-1, -1, -1};
    tacc = '{-1, -1};
    bf_req_data  = bb[0];
    bf_req_valid = 1'b1;
    chk_i("b2b_first_ready", int'(bcci_req_ready), 1);
    tick();
    widx = 1;
    bf_req_data = bb[1];
    nout = 0;
    nacc = 0;
    for (int i = 1; i <= 14; i++) begin
      rv  = bcci_rsp_valid;
      acc = bcci_req_ready && bf_req_valid;
      if (rv && nout < 3) begin
        bgot[nout] = bcci_rsp_data;
        tout[nout] = i;
        nout++;
      end
      if (acc && nacc < 2) begin
        tacc[nacc] = i;
        nacc++;
      end
      tick();
      if (acc) begin
        widx++;
        if (widx < 3) bf_req_data = bb[widx];
        else bf_req_valid = 1'b0;
      end
    end
    chk_i("b2b_outputs", nout, 3);
    for (int k = 0; k < 3; k++) begin
      chk_i($sformatf("b2b_out%0d_time", k), tout[k], 4 * (k + 1));
      if (k < nout) chk($sformatf("b2b_out%0d_data", k), bgot[k], bb[k]);
    end
    chk_i("b2b_acc1_time", tacc[0], 4);
    chk_i("b2b_acc2_time", tacc[1], 8);

    // Downstream backpressure for 10 cycles while presenting a result
    bf_rsp_ready = 1'b0;
    exp_w = mk_flat(8'h5A, 8'hA5, 8'h3C);
`ifdef BCCI_PERF_CNT_EN
    s0 = int'(perf_stall_cnt);
`endif
    send(exp_w, 0, 0, got, lat);
    chk_i("bp_latency", lat, 4);
    bf_req_valid = 1'b1;
    bf_req_data  = mk_flat(8'h01, 8'h01, 8'h01);
    bad = 0;
    for (int j = 0; j < 10; j++) begin
      if (!bcci_rsp_valid || bcci_rsp_data !== exp_w || bcci_req_ready) bad++;
      tick();
    end
    chk_i("bp_hold_bad_cycles", bad, 0);
    bf_req_valid = 1'b0;
    bf_rsp_ready = 1'b1;
    chk("bp_data_at_release", bcci_rsp_data, exp_w);
    h0 = hs_cnt;
    v0 = vld_cnt;
    tick();
    chk_i("bp_valid_after", int'(bcci_rsp_valid), 0);
    chk_i("bp_handshakes", hs_cnt - h0, 1);
`ifdef BCCI_PERF_CNT_EN
    chk_i("bp_perf_stall", int'(perf_stall_cnt) - s0, 10);
`endif

    // Core stall for 2 cycles in the G channel
    c0 = creq_cnt;
    send(mk_flat(8'h11, 8'h22, 8'h33), 1, 2, got, lat);
    chk_i("cstall_latency", lat, 6);
    chk("cstall_data", got, mk_flat(8'h11, 8'h22, 8'h33));
    tick();
    chk_i("cstall_core_req_cycles", creq_cnt - c0, 5);

    // Reset asserted while processing channel 1
    bf_req_data  = mk_flat(8'h77, 8'h88, 8'h99);
    bf_req_valid = 1'b1;
    chk_i("rmid_ready", int'(bcci_req_ready), 1);
    tick();
    bf_req_valid = 1'b0;
    tick();
    chk_i("rmid_in_ch1", int'(core_req_valid), 1);
    rst_n = 1'b0;
    #1;
    chk_i("rmid_async_core_req", int'(core_req_valid), 0);
    chk_i("rmid_async_rsp_valid", int'(bcci_rsp_valid), 0);
    tick();
    rst_n = 1'b1;
    v0 = vld_cnt;
    tick();
    chk_i("rmid_ready_after", int'(bcci_req_ready), 1);
    chk_i("rmid_valid_after", int'(bcci_rsp_valid), 0);
    chk("rmid_data_cleared", bcci_rsp_data, '0);
    repeat (8) tick();
    chk_i("rmid_no_stale_output", vld_cnt - v0, 0);

    // Channel isolation with an R-only ramp
    for (int k = 0; k < 16; k++) ramp[k*8 +: 8] = 8'(k);
    send(mk_win(ramp, '0, '0), 0, 0, got, lat);
    chk_i("ramp_latency", lat, 4);
    chk("ramp_g_zero", W'(plane(got, 1)), '0);
    chk("ramp_b_zero", W'(plane(got, 2)), '0);
    chk("ramp_r_model", W'(plane(got, 0)), W'(core_model(ramp)));
    chk_i("ramp_r_out0", int'(got[0*24 +: 8]), 5);
    chk_i("ramp_r_out5", int'(got[5*24 +: 8]), 8);
    chk_i("ramp_r_out15", int'(got[15*24 +: 8]), 13);
    tick();
    chk_i("ramp_idle_after", int'(bcci_req_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
